// File: rtl/cdc_toggle_pulse_sender_pkg.sv
// ---------------------------------------------------------------------------
// cdc_toggle_pulse_sender_pkg
// Shared types for the source-domain half of the toggle-handshake crossing.
//   state_e : handshake FSM encoding (IDLE = no request outstanding,
//             WAIT = request toggled, waiting for the acknowledge toggle).
// ---------------------------------------------------------------------------
package cdc_toggle_pulse_sender_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage : cdc_toggle_pulse_sender_pkg

// File: rtl/cdc_toggle_pulse_sender_if.sv
// ---------------------------------------------------------------------------
// cdc_toggle_pulse_sender_if
// Groups the event, handshake and status signals of the pulse sender.
//   PULSE_IN    : one event per high cycle (source domain)
//   CLEAR       : single-cycle clear of the sticky flags
//   ACK_IN      : acknowledge toggle from the foreign clock domain
//   REQ_OUT     : request toggle to the foreign clock domain
//   BUSY        : request outstanding or events queued
//   PENDING     : queued events not yet sent
//   OVERFLOW    : sticky, an event was dropped at saturation
//   TIMEOUT_ERR : sticky, acknowledge wait exceeded the limit
// modport master : the sender block itself
// modport slave  : the environment feeding events and the receiver ack
// ---------------------------------------------------------------------------
interface cdc_toggle_pulse_sender_if #(
    parameter int PENDING_WIDTH = 4
);
    logic                     PULSE_IN;
    logic                     CLEAR;
    logic                     ACK_IN;
    logic                     REQ_OUT;
    logic                     BUSY;
    logic [PENDING_WIDTH-1:0] PENDING;
    logic                     OVERFLOW;
    logic                     TIMEOUT_ERR;

    modport master (
        input  PULSE_IN,
        input  CLEAR,
        input  ACK_IN,
        output REQ_OUT,
        output BUSY,
        output PENDING,
        output OVERFLOW,
        output TIMEOUT_ERR
    );

    modport slave (
        output PULSE_IN,
        output CLEAR,
        output ACK_IN,
        input  REQ_OUT,
        input  BUSY,
        input  PENDING,
        input  OVERFLOW,
        input  TIMEOUT_ERR
    );

endinterface : cdc_toggle_pulse_sender_if

// File: rtl/cdc_toggle_pulse_sender_sync.sv
// ---------------------------------------------------------------------------
// three_stage_synchronizer
// Brings an asynchronous signal into the CLK domain through three flops.
// A change on async_in before edge e0 appears on sync_out after edge e2.
//   CLK      : destination clock
//   RESET    : synchronous active-high reset, clears all stages
//   async_in : signal from a foreign clock domain
//   sync_out : synchronized copy
// ---------------------------------------------------------------------------
module three_stage_synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] mid_r;
    logic [WIDTH-1:0] out_r;

    // Three-flop shift chain; the first stage may go metastable
    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta_r <= {WIDTH{1'b0}};
            mid_r  <= {WIDTH{1'b0}};
            out_r  <= {WIDTH{1'b0}};
        end else begin
            meta_r <= async_in;
            mid_r  <= meta_r;
            out_r  <= mid_r;
        end
    end

    assign sync_out = out_r;

endmodule : three_stage_synchronizer

// File: rtl/cdc_toggle_pulse_sender.sv
// ---------------------------------------------------------------------------
// cdc_toggle_pulse_sender
// Source-domain half of a toggle-handshake crossing. Event pulses are queued
// in a saturating counter; one request toggle is sent per event, and the
// next toggle waits until the receiver's acknowledge toggle has come back
// through the synchronizer (ack == req means "in sync").
//   CLK   : source-domain clock, rising edge
//   RESET : synchronous active-high reset
//   bus   : cdc_toggle_pulse_sender_if.master (events, handshake, status)
// Parameters:
//   PENDING_WIDTH : pending counter width (max queued = 2^W-1)
//   TIMEOUT_WIDTH : acknowledge-wait counter width
//   TIMEOUT       : WAIT cycles before TIMEOUT_ERR; 0 disables it
// ---------------------------------------------------------------------------
module cdc_toggle_pulse_sender
    import cdc_toggle_pulse_sender_pkg::*;
#(
    parameter int PENDING_WIDTH = 4,
    parameter int TIMEOUT_WIDTH = 16,
    parameter int TIMEOUT       = 0
) (
    input  logic                      CLK,
    input  logic                      RESET,
    cdc_toggle_pulse_sender_if.master bus
);

    localparam logic [PENDING_WIDTH-1:0] PENDING_MAX  = {PENDING_WIDTH{1'b1}};
    localparam logic [PENDING_WIDTH-1:0] PENDING_ZERO = {PENDING_WIDTH{1'b0}};
    localparam logic [PENDING_WIDTH-1:0] PENDING_ONE  = PENDING_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_MAX     = {TIMEOUT_WIDTH{1'b1}};
    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_ZERO    = {TIMEOUT_WIDTH{1'b0}};
    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_ONE     = TIMEOUT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_VAL  = TIMEOUT_WIDTH'(TIMEOUT);
    localparam logic                     TIMEOUT_EN   = (TIMEOUT != 0);

    state_e                   state_r;
    state_e                   state_nx_s;
    logic                     req_r;
    logic                     req_nx_s;
    logic [PENDING_WIDTH-1:0] pending_r;
    logic [PENDING_WIDTH-1:0] pending_nx_s;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt_r;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt_nx_s;
    logic [TIMEOUT_WIDTH-1:0] wait_inc_s;
    logic                     overflow_r;
    logic                     overflow_nx_s;
    logic                     timeout_err_r;
    logic                     timeout_err_nx_s;
    logic                     busy_r;
    logic                     busy_nx_s;
    logic                     ack_s;
    logic                     in_sync_s;
    logic                     has_pending_s;
    logic                     issue_s;
    logic                     ovf_set_s;
    logic                     timeout_hit_s;

    // ACK_IN is only ever consumed through this synchronizer
    three_stage_synchronizer #(
        .WIDTH (1)
    ) u_ack_sync (
        .CLK      (CLK),
        .RESET    (RESET),
        .async_in (bus.ACK_IN),
        .sync_out (ack_s)
    );

    assign in_sync_s     = (ack_s == req_r);
    assign has_pending_s = (pending_r != PENDING_ZERO);
    assign wait_inc_s    = (wait_cnt_r == WAIT_MAX) ? wait_cnt_r : (wait_cnt_r + WAIT_ONE);

    // Handshake FSM: decides when to issue a toggle and runs the wait counter
    always_comb begin
        state_nx_s    = state_r;
        wait_cnt_nx_s = wait_cnt_r;
        issue_s       = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wait_cnt_nx_s = WAIT_ZERO;
                if (has_pending_s && in_sync_s) begin
                    issue_s    = 1'b1;
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (in_sync_s && has_pending_s) begin
                    // back-to-back issue, no IDLE cycle in between
                    issue_s       = 1'b1;
                    wait_cnt_nx_s = WAIT_ZERO;
                    state_nx_s    = ST_WAIT;
                end else if (in_sync_s) begin
                    wait_cnt_nx_s = WAIT_ZERO;
                    state_nx_s    = ST_IDLE;
                end else begin
                    // flag on the cycle the counter lands on TIMEOUT, keep waiting
                    wait_cnt_nx_s = wait_inc_s;
                    timeout_hit_s = TIMEOUT_EN && (wait_inc_s == TIMEOUT_VAL);
                    state_nx_s    = ST_WAIT;
                end
            end
            default: begin
                wait_cnt_nx_s = WAIT_ZERO;
                state_nx_s    = ST_IDLE;
            end
        endcase
    end

    // Request toggle, saturating pending counter, sticky flags and busy
    always_comb begin
        pending_nx_s = pending_r;
        ovf_set_s    = 1'b0;
        if (issue_s) begin
            req_nx_s = ~req_r;
        end else begin
            req_nx_s = req_r;
        end
        if (bus.PULSE_IN && !issue_s) begin
            if (pending_r == PENDING_MAX) begin
                pending_nx_s = pending_r;
                ovf_set_s    = 1'b1;
            end else begin
                pending_nx_s = pending_r + PENDING_ONE;
            end
        end else if (!bus.PULSE_IN && issue_s) begin
            pending_nx_s = pending_r - PENDING_ONE;
        end else begin
            // both or neither: count unchanged, even at saturation
            pending_nx_s = pending_r;
        end
        // a set in the same cycle as CLEAR keeps the flag high
        overflow_nx_s    = ovf_set_s | (overflow_r & ~bus.CLEAR);
        timeout_err_nx_s = timeout_hit_s | (timeout_err_r & ~bus.CLEAR);
        busy_nx_s        = (state_nx_s == ST_WAIT) || (pending_nx_s != PENDING_ZERO);
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r       <= ST_IDLE;
            req_r         <= 1'b0;
            pending_r     <= PENDING_ZERO;
            wait_cnt_r    <= WAIT_ZERO;
            overflow_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            req_r         <= req_nx_s;
            pending_r     <= pending_nx_s;
            wait_cnt_r    <= wait_cnt_nx_s;
            overflow_r    <= overflow_nx_s;
            timeout_err_r <= timeout_err_nx_s;
            busy_r        <= busy_nx_s;
        end
    end

    assign bus.REQ_OUT     = req_r;
    assign bus.PENDING     = pending_r;
    assign bus.OVERFLOW    = overflow_r;
    assign bus.TIMEOUT_ERR = timeout_err_r;
    assign bus.BUSY        = busy_r;

endmodule : cdc_toggle_pulse_sender

// File: doc/cdc_toggle_pulse_sender.md
Name: cdc_toggle_pulse_sender

Overview:
Source-domain half of a toggle-handshake clock-domain crossing. It accepts single-cycle event pulses, queues them in a saturating pending counter and drives a level-toggle request line to a receiver in a foreign clock domain. It does not send the next toggle until the receiver's returned acknowledge toggle has been synchronized back into CLK. It sits beside the synchronizers on every pulse- or flag-carrying path between clock domains.

Parameters:
PENDING_WIDTH, 4, width of the pending-event counter; maximum queued events = 2^PENDING_WIDTH-1.
TIMEOUT_WIDTH, 16, width of the acknowledge-wait counter.
TIMEOUT, 0, cycles in WAIT before TIMEOUT_ERR is flagged; 0 disables the timeout.

Ports:
CLK  input  1  source-domain clock; all logic on the rising edge.
RESET  input  1  synchronous, active-high reset.
PULSE_IN  input  1  each high cycle is one event to transfer.
CLEAR  input  1  single-cycle clear of the sticky OVERFLOW and TIMEOUT_ERR flags.
ACK_IN  input  1  asynchronous acknowledge toggle from the receiver domain.
REQ_OUT  output  1  registered request toggle to the receiver domain.
BUSY  output  1  high when state is WAIT or PENDING != 0.
PENDING  output  PENDING_WIDTH  events queued and not yet sent.
OVERFLOW  output  1  sticky: an event was dropped at saturation.
TIMEOUT_ERR  output  1  sticky: acknowledge wait exceeded TIMEOUT.

Behaviour:
- Reset state:
  - REQ_OUT=0, PENDING=0, OVERFLOW=0, TIMEOUT_ERR=0.
  - Synchronizer stages = 0, wait counter = 0, state = IDLE.
- ACK_IN synchronization:
  - ACK_IN passes through 3 flip-flops to form ack_s.
  - ACK_IN is never used unsynchronized.
  - A change on ACK_IN before edge e0 is visible on ack_s after edge e2.
- Handshake is "in sync" when ack_s == REQ_OUT.
- "Issue" means: toggle REQ_OUT, decrement PENDING, clear the wait counter, enter or stay in WAIT.
- IDLE:
  - If PENDING != 0 and in sync, issue.
  - Otherwise stay in IDLE. The timeout does not run in IDLE.
- WAIT:
  - The wait counter increments each cycle and saturates.
  - When in sync and PENDING != 0, issue again directly (back-to-back, no IDLE cycle).
  - When in sync and PENDING == 0, go to IDLE.
  - When the wait counter reaches TIMEOUT (TIMEOUT != 0), set TIMEOUT_ERR and remain in WAIT. The protocol is not abandoned.
- Latency:
  - PULSE_IN high in cycle n gives PENDING=1 in n+1.
  - From IDLE and in sync, REQ_OUT toggles in n+2 and PENDING returns to 0.
  - Minimum request-to-request spacing = receiver round trip + 3 synchronizer cycles + 1.
- Pending counter:
  - +1 on PULSE_IN, -1 on issue.
  - Both in the same cycle: no change.
  - PULSE_IN at max with no issue: value held and OVERFLOW set.
  - PULSE_IN at max with a simultaneous issue: held, no overflow.
- Sticky flags:
  - CLEAR clears OVERFLOW and TIMEOUT_ERR.
  - A set event in the same cycle as CLEAR wins (flag stays 1).
- Reset mid-operation:
  - Everything returns to reset values and queued events are discarded.
  - If the receiver is not reset too and ACK_IN stays 1, the block stays IDLE with BUSY=1 while events are pending, and no request is issued. The receiver-domain reset must be applied together with RESET.
- PENDING_WIDTH >= 1 and TIMEOUT < 2^TIMEOUT_WIDTH are required. The wait counter is TIMEOUT_WIDTH bits and compares for equality with TIMEOUT.

Decomposition:
- No shared package is needed.
- Local constants: state encoding (IDLE=0, WAIT=1) and PENDING_MAX = {PENDING_WIDTH{1'b1}}.
- One natural sub-module: three_stage_synchronizer (WIDTH=1) instance for ACK_IN.
- An optional mirror block, cdc_toggle_pulse_receiver, is the bench's far-end model.

Test Plan:
- Single event: PULSE_IN 1 cycle, loopback ACK_IN=REQ_OUT delayed 5 cycles -> REQ_OUT 0->1 two cycles after the pulse; BUSY falls 4 cycles after ACK_IN toggles; PENDING back to 0.
- Burst: 5 consecutive PULSE_IN cycles, loopback delay 2 -> exactly 5 REQ_OUT toggles, back-to-back with no IDLE gap; PENDING peaks at 4; OVERFLOW=0.
- Saturation: PENDING_WIDTH=2, ACK_IN held, 6 pulses -> PENDING=3; OVERFLOW=1; CLEAR then clears it; after the ack is released exactly 4 toggles in total.
- Simultaneous: PULSE_IN high in the same cycle as an issue with PENDING=3 (max) -> PENDING stays 3; OVERFLOW stays 0.
- Timeout: TIMEOUT=10, ACK_IN never toggles -> TIMEOUT_ERR=1 exactly 10 cycles after the REQ_OUT toggle; state stays WAIT; a late ACK_IN toggle returns the block to IDLE.
- Reset mid-wait: RESET during WAIT with PENDING=2 -> next cycle REQ_OUT=0, PENDING=0, BUSY=0; ACK_IN forced to 1 after reset plus one pulse -> BUSY=1 and no toggle until ACK_IN=0.
